// File: rtl/keypad_matrix_driver_if.sv
// Keypad matrix pin and key-vector bundle.
// The master side (the driver) strobes the columns, reads the rows and
// produces the debounced key vector. The slave side is the keypad pins and
// the scan block that consumes the vector.
interface keypad_matrix_driver_if;
  logic [3:0]  row_in;      // matrix row lines, 1 = key in active column pressed
  logic [2:0]  col_out;     // one-hot column strobe, active-high
  logic [11:0] keypad_out;  // debounced one-hot key vector, bit = row*3 + col
  logic        frame_done;  // one-cycle pulse on the last cycle of each frame

  modport master (
    input  row_in,
    output col_out,
    output keypad_out,
    output frame_done
  );

  modport slave (
    output row_in,
    input  col_out,
    input  keypad_out,
    input  frame_done
  );
endinterface

// File: rtl/keypad_matrix_driver.sv
// Keypad matrix driver for a 4-row x 3-column keypad.
// Strobes one column at a time, samples the synchronised rows at the end of
// each column dwell, assembles a 12-bit frame and debounces it over several
// complete frames. Only a frame with exactly one key set is reported; empty
// or multi-key frames report zero, which also suppresses ghost keys.
module keypad_matrix_driver #(
  parameter int CLK_PER_COL    = 250,  // dwell per column in clocks, >= 4
  parameter int DEBOUNCE_SCANS = 3     // identical frames needed, >= 1
) (
  input  logic                  clk,
  input  logic                  rst,
  keypad_matrix_driver_if.master kp
);

  localparam int DW = (CLK_PER_COL > 1) ? $clog2(CLK_PER_COL) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(CLK_PER_COL - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2
  } col_state_t;

  // Synchroniser
  logic [3:0]    r_row_meta;
  logic [3:0]    r_row_s;

  // Column sequencing
  logic [DW-1:0] r_dwell;
  logic          w_last_dwell;
  col_state_t    r_state;
  col_state_t    w_state_next;
  logic [2:0]    r_col_out;
  logic [2:0]    w_col_next;
  logic          w_frame_end;

  // Frame assembly and debounce
  logic [11:0]   r_frame;
  logic [11:0]   w_frame_merged;
  logic [11:0]   r_prev;
  logic          w_same;
  logic          w_single;
  logic [11:0]   w_filtered;
  logic [SW-1:0] r_stable;
  logic [SW-1:0] w_stable_next;
  logic          w_load;
  logic [11:0]   r_keypad;

  // Two-flop synchroniser for the asynchronous row lines
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_meta <= '0;
      r_row_s    <= '0;
    end else begin
      r_row_meta <= kp.row_in;
      r_row_s    <= r_row_meta;
    end
  end

  assign w_last_dwell = (r_dwell == DWELL_LAST);

  // Dwell counter: 0 .. CLK_PER_COL-1, restarting with every column
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell <= '0;
    end else if (w_last_dwell) begin
      r_dwell <= '0;
    end else begin
      r_dwell <= r_dwell + 1'b1;
    end
  end

  // Column sequencer state and registered one-hot strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= COL0;
      r_col_out <= 3'b001;
    end else begin
      r_state   <= w_state_next;
      r_col_out <= w_col_next;
    end
  end

  // Column sequencer next state; the frame ends on the last dwell of column 2
  always_comb begin
    w_state_next = r_state;
    w_col_next   = r_col_out;
    w_frame_end  = 1'b0;
    case (r_state)
      COL0: begin
        if (w_last_dwell) begin
          w_state_next = COL1;
          w_col_next   = 3'b010;
        end
      end
      COL1: begin
        if (w_last_dwell) begin
          w_state_next = COL2;
          w_col_next   = 3'b100;
        end
      end
      COL2: begin
        w_frame_end = w_last_dwell;
        if (w_last_dwell) begin
          w_state_next = COL0;
          w_col_next   = 3'b001;
        end
      end
      default: begin
        w_state_next = COL0;
        w_col_next   = 3'b001;
      end
    endcase
  end

  // Frame with the active column's bits replaced by the current row sample.
  // Bit gi belongs to row gi/3 and column gi%3.
  generate
    for (genvar gi = 0; gi < 12; gi++) begin : g_frame_bit
      assign w_frame_merged[gi] = r_col_out[gi % 3] ? r_row_s[gi / 3] : r_frame[gi];
    end
  endgenerate

  // Frame register: capture a column at the end of its dwell, clear after the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame <= '0;
    end else if (w_frame_end) begin
      r_frame <= '0;
    end else if (w_last_dwell) begin
      r_frame <= w_frame_merged;
    end
  end

  assign w_same     = (w_frame_merged == r_prev);
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
  assign w_single   = (w_frame_merged != 12'h000) &&
                      ((w_frame_merged & (w_frame_merged - 12'h001)) == 12'h000);
  assign w_filtered = w_single ? w_frame_merged : 12'h000;

  // Debounce count update and output-load decision at each frame end
  always_comb begin
    w_stable_next = r_stable;
    w_load        = 1'b0;
    if (w_frame_end) begin
      if (!w_same) begin
        w_stable_next = SW'(1);
      end else if (r_stable < STABLE_MAX) begin
        w_stable_next = r_stable + 1'b1;
      end
      // Load only when the count reaches saturation on this frame; a frame that
      // merely repeats an already-saturated pattern leaves the output alone.
      w_load = (w_stable_next == STABLE_MAX) && !(w_same && (r_stable == STABLE_MAX));
    end
  end

  // Debounce state and key vector output; idle after reset counts as stable
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= STABLE_MAX;
      r_prev   <= '0;
      r_keypad <= '0;
    end else begin
      r_stable <= w_stable_next;
      if (w_frame_end) begin
        r_prev <= w_frame_merged;
      end
      if (w_load) begin
        r_keypad <= w_filtered;
      end
    end
  end

  assign kp.col_out    = r_col_out;
  assign kp.keypad_out = r_keypad;
  assign kp.frame_done = w_frame_end;

endmodule

// File: tb/tb_keypad_matrix_driver.sv
// Testbench for keypad_matrix_driver: models the key matrix, predicts the
// debounced key vector from frame run lengths and checks it through a queue.
module tb_keypad_matrix_driver;
  localparam int CPC   = 4;
  localparam int DS    = 3;
  localparam int FRAME = 3 * CPC;
  localparam int HN    = 16384;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_matrix_driver_if kp_if();

  keypad_matrix_driver #(
    .CLK_PER_COL(CPC),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp(kp_if)
  );

  logic [11:0] keys = '0;  // held keys, bit = row*3 + col

  int tests_run    = 0;
  int tests_failed = 0;

  // Key matrix: a row reads 1 when a held key sits in the strobed column
  always_comb begin
    kp_if.row_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && kp_if.col_out[c]) kp_if.row_in[r] = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle index since reset, key history, frame run length
  int          cyc   = 0;
  logic        rst_q = 1'b1;
  logic [11:0] hist [0:HN-1];
  logic [11:0] m_prev = '0;
  int          m_run  = 1 << 20;
  logic [11:0] m_kp   = '0;
  logic [11:0] exp_q [$];

  always @(posedge clk) begin
    logic [11:0] f;
    logic [11:0] snap;
    logic [11:0] kp_new;
    int          run_new;
    if (rst) begin
      cyc    <= 0;
      rst_q  <= 1'b1;
      m_prev <= '0;
      m_run  <= 1 << 20;
      m_kp   <= '0;
      exp_q.delete();
    end else begin
      rst_q <= 1'b0;
      hist[cyc % HN] <= keys;
      cyc <= cyc + 1;
      if (cyc % FRAME == FRAME - 1) begin
        // Column c is sampled on its last dwell cycle and sees the keys
        // that were present two clocks earlier (synchroniser).
        f = '0;
        for (int c = 0; c < 3; c++) begin
          snap = hist[(cyc - (2 - c) * CPC - 2) % HN];
          for (int r = 0; r < 4; r++) f[r*3+c] = snap[r*3+c];
        end
        run_new = (f == m_prev) ? m_run + 1 : 1;
        kp_new  = m_kp;
        if (run_new == DS) kp_new = ($countones(f) == 1) ? f : 12'h000;
        exp_q.push_back(kp_new);
        m_kp   <= kp_new;
        m_prev <= f;
        m_run  <= run_new;
      end
    end
  end

  // Monitor: strobe sequence, frame pulse and key vector checked every cycle
  logic        pending = 1'b0;
  logic [11:0] cur_exp = '0;

  always @(negedge clk) begin
    if (rst_q) begin
      chk("reset_col_out", 32'(kp_if.col_out), 32'h1);
      chk("reset_keypad_out", 32'(kp_if.keypad_out), 32'h0);
      chk("reset_frame_done", 32'(kp_if.frame_done), 32'h0);
      pending = 1'b0;
      cur_exp = '0;
    end else begin
      chk("col_out", 32'(kp_if.col_out), 32'(3'b001 << ((cyc / CPC) % 3)));
      chk("frame_done", 32'(kp_if.frame_done), 32'((cyc % FRAME) == FRAME - 1));
      if (pending) begin
        pending = 1'b0;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL scoreboard_empty: frame_done without predicted frame at %0t", $time);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      chk("keypad_out", 32'(kp_if.keypad_out), 32'(cur_exp));
      if (kp_if.frame_done) pending = 1'b1;
    end
  end

  // Advance to the next negedge on which frame_done is high, bounded
  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!kp_if.frame_done && n < 100);
    if (!kp_if.frame_done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL frame_done_timeout: got 0 expected 1 within 100 cycles at %0t", $time);
    end
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < n; i++) wait_fd();
  endtask

  initial begin
    logic [11:0] base;
    int          sel;
    int          hold;
    int          a;
    int          b;
    logic        bounce;

    // 1: reset held for two edges
    rst  = 1'b1;
    keys = '0;
    repeat (2) @(negedge clk);
    chk("dir_reset_col", 32'(kp_if.col_out), 32'h1);
    chk("dir_reset_kp", 32'(kp_if.keypad_out), 32'h0);
    rst = 1'b0;

    // 2: idle scanning
    wait_frames(4);
    chk("dir_idle_kp", 32'(kp_if.keypad_out), 32'h0);

    // 3: key (0,0) pressed at a frame boundary; exact latency both ways
    keys = 12'h001;
    wait_frames(3);
    chk("dir_press_not_yet", 32'(kp_if.keypad_out), 32'h0);
    @(negedge clk);
    chk("dir_press_00", 32'(kp_if.keypad_out), 32'h001);
    keys = 12'h000;
    wait_frames(3);
    chk("dir_release_not_yet", 32'(kp_if.keypad_out), 32'h001);
    @(negedge clk);
    chk("dir_release_00", 32'(kp_if.keypad_out), 32'h000);

    // 4: key (1,2), then directly to key (0,0)
    keys = 12'h020;
    wait_frames(4);
    @(negedge clk);
    chk("dir_key_12", 32'(kp_if.keypad_out), 32'h020);
    keys = 12'h001;
    wait_frames(4);
    @(negedge clk);
    chk("dir_switch_00", 32'(kp_if.keypad_out), 32'h001);

    // 5: release, short press, bounce, then a solid hold
    keys = 12'h000;
    wait_frames(4);
    @(negedge clk);
    chk("dir_release_again", 32'(kp_if.keypad_out), 32'h000);
    wait_fd();
    keys = 12'h001;
    wait_frames(2);
    keys = 12'h000;
    wait_frames(4);
    chk("dir_short_press", 32'(kp_if.keypad_out), 32'h000);
    for (int j = 0; j < 5 * FRAME; j++) begin
      @(negedge clk);
      keys = ((j / 5) % 2 == 0) ? 12'h001 : 12'h000;
    end
    keys = 12'h001;
    wait_frames(4);
    @(negedge clk);
    chk("dir_hold_after_bounce", 32'(kp_if.keypad_out), 32'h001);

    // 6: two keys together are rejected; then reset mid-column
    keys = 12'h000;
    wait_frames(4);
    keys = 12'h021;
    wait_frames(5);
    @(negedge clk);
    chk("dir_multi_key", 32'(kp_if.keypad_out), 32'h000);
    keys = 12'h020;
    wait_frames(4);
    @(negedge clk);
    chk("dir_before_reset", 32'(kp_if.keypad_out), 32'h020);
    wait_fd();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("dir_midreset_col", 32'(kp_if.col_out), 32'h1);
    chk("dir_midreset_kp", 32'(kp_if.keypad_out), 32'h0);
    chk("dir_midreset_fd", 32'(kp_if.frame_done), 32'h0);
    rst = 1'b0;
    wait_frames(4);
    @(negedge clk);
    chk("dir_after_reset", 32'(kp_if.keypad_out), 32'h020);

    // Random key patterns with random hold times and occasional bounce
    for (int i = 0; i < 40; i++) begin
      sel  = int'($urandom_range(0, 9));
      base = '0;
      if (sel >= 3 && sel <= 7) begin
        a = int'($urandom_range(0, 11));
        base[a] = 1'b1;
      end else if (sel >= 8) begin
        a = int'($urandom_range(0, 11));
        b = int'($urandom_range(0, 11));
        base[a] = 1'b1;
        base[b] = 1'b1;
      end
      hold   = int'($urandom_range(4, 60));
      bounce = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < hold; j++) begin
        keys = (bounce && ((j / 5) % 2 == 1)) ? 12'h000 : base;
        @(negedge clk);
      end
    end

    keys = '0;
    wait_frames(5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
